// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants.
// Used by the timing generator, the pixel controller and the text path so they
// all agree on frame geometry, sync placement and sync polarity.
// No ports (package).
package vga_timing_pkg;

  // Horizontal timing, in pixel ticks.
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  // Vertical timing, in lines.
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync level while the pulse is asserted (0 = active-low).
  localparam bit DEF_HS_POL = 1'b0;
  localparam bit DEF_VS_POL = 1'b0;

  // Sync windows: start inclusive, end exclusive.
  localparam int unsigned DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int unsigned DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  // Pixel ticks between a counter value and the matching sync/blank at the pins.
  localparam int unsigned DEF_PIPE_DELAY = 2;

  // Bundle carried through the sync delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_bits_t;

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register that delays the sync/blank bundle.
// Ports:
//   clk   in   pixel clock
//   rst   in   synchronous active-high reset; all stages load INACTIVE
//   en    in   pixel-tick enable; stages shift only when high
//   din   in   WIDTH-bit value entering stage 0
//   dout  out  last stage (din delayed by DEPTH enabled ticks)
module vga_sync_delay #(
  parameter int unsigned     DEPTH    = 2,
  parameter int unsigned     WIDTH    = 3,
  parameter logic [WIDTH-1:0] INACTIVE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      // Flush every stage so no stale sync pulse drains out after reset.
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= INACTIVE;
      end
    end else if (en) begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_generator.sv
// Raster timing source for the pixel controller.
// Produces the pixel counters plus sync/blank delayed by PIPE_DELAY pixel ticks so
// they line up with pixel data produced PIPE_DELAY ticks after each counter value.
// Ports:
//   CLOCK        in   pixel-domain clock
//   RESET        in   synchronous active-high reset (overrides PIX_EN)
//   PIX_EN       in   pixel-tick enable; all state advances only when high
//   CounterX     out  horizontal position 0..H_TOTAL-1
//   CounterY     out  vertical position 0..V_TOTAL-1
//   ActiveArea   out  counters inside the visible area (aligned to counters)
//   FrameStart   out  one-tick pulse while counters are (0,0)
//   VGA_HS       out  horizontal sync, delayed PIPE_DELAY ticks
//   VGA_VS       out  vertical sync, delayed PIPE_DELAY ticks
//   VGA_BLANK_N  out  delayed ActiveArea (1 = drive pixel)
//   VGA_SYNC_N   out  constant 0 (no sync-on-green)
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNTR_WIDTH_H = 11,
  parameter int unsigned CNTR_WIDTH_V = 10,
  parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned H_FP         = DEF_H_FP,
  parameter int unsigned H_SYNC       = DEF_H_SYNC,
  parameter int unsigned H_BP         = DEF_H_BP,
  parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
  parameter int unsigned V_FP         = DEF_V_FP,
  parameter int unsigned V_SYNC       = DEF_V_SYNC,
  parameter int unsigned V_BP         = DEF_V_BP,
  parameter bit          HS_POL       = DEF_HS_POL,
  parameter bit          VS_POL       = DEF_VS_POL,
  parameter int unsigned PIPE_DELAY   = DEF_PIPE_DELAY
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    PIX_EN,
  output logic [CNTR_WIDTH_H-1:0] CounterX,
  output logic [CNTR_WIDTH_V-1:0] CounterY,
  output logic                    ActiveArea,
  output logic                    FrameStart,
  output logic                    VGA_HS,
  output logic                    VGA_VS,
  output logic                    VGA_BLANK_N,
  output logic                    VGA_SYNC_N
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Elaboration-time sanity checks on geometry and delay depth.
  if (H_TOTAL > (64'd1 << CNTR_WIDTH_H)) begin : g_bad_h_width
    $error("H_TOTAL %0d does not fit in CNTR_WIDTH_H %0d", H_TOTAL, CNTR_WIDTH_H);
  end
  if (V_TOTAL > (64'd1 << CNTR_WIDTH_V)) begin : g_bad_v_width
    $error("V_TOTAL %0d does not fit in CNTR_WIDTH_V %0d", V_TOTAL, CNTR_WIDTH_V);
  end
  if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_delay
    $error("PIPE_DELAY %0d outside 1..8", PIPE_DELAY);
  end

  // Inclusive last values so no bound ever needs to reach 2^width.
  localparam logic [CNTR_WIDTH_H-1:0] X_LAST     = CNTR_WIDTH_H'(H_TOTAL - 1);
  localparam logic [CNTR_WIDTH_H-1:0] X_ACT_LAST = CNTR_WIDTH_H'(H_ACTIVE - 1);
  localparam logic [CNTR_WIDTH_H-1:0] HS_FIRST   = CNTR_WIDTH_H'(H_ACTIVE + H_FP);
  localparam logic [CNTR_WIDTH_H-1:0] HS_LAST    = CNTR_WIDTH_H'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNTR_WIDTH_V-1:0] Y_LAST     = CNTR_WIDTH_V'(V_TOTAL - 1);
  localparam logic [CNTR_WIDTH_V-1:0] Y_ACT_LAST = CNTR_WIDTH_V'(V_ACTIVE - 1);
  localparam logic [CNTR_WIDTH_V-1:0] VS_FIRST   = CNTR_WIDTH_V'(V_ACTIVE + V_FP);
  localparam logic [CNTR_WIDTH_V-1:0] VS_LAST    = CNTR_WIDTH_V'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam sync_bits_t SYNC_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, active: 1'b0};

  logic [CNTR_WIDTH_H-1:0] x_next;
  logic [CNTR_WIDTH_V-1:0] y_next;
  logic                    hs_next;
  logic                    vs_next;
  logic                    active_next;
  logic                    frame_next;
  logic                    hs_raw;
  logic                    vs_raw;
  sync_bits_t              delay_in;
  sync_bits_t              delay_out;

  // Next counter position; a Y step only happens on the last pixel of a line.
  always_comb begin
    x_next = CounterX;
    y_next = CounterY;
    if (CounterX == X_LAST) begin
      x_next = '0;
      if (CounterY == Y_LAST) begin
        y_next = '0;
      end else begin
        y_next = CounterY + CNTR_WIDTH_V'(1);
      end
    end else begin
      x_next = CounterX + CNTR_WIDTH_H'(1);
    end
  end

  // Decode from the next position so the registered flags share the counters' cycle.
  always_comb begin
    hs_next     = ~HS_POL;
    vs_next     = ~VS_POL;
    active_next = 1'b0;
    frame_next  = 1'b0;
    if (x_next >= HS_FIRST && x_next <= HS_LAST) begin
      hs_next = HS_POL;
    end
    if (y_next >= VS_FIRST && y_next <= VS_LAST) begin
      vs_next = VS_POL;
    end
    if (x_next <= X_ACT_LAST && y_next <= Y_ACT_LAST) begin
      active_next = 1'b1;
    end
    if (x_next == '0 && y_next == '0) begin
      frame_next = 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      CounterX   <= '0;
      CounterY   <= '0;
      ActiveArea <= 1'b0;
      FrameStart <= 1'b0;
      hs_raw     <= ~HS_POL;
      vs_raw     <= ~VS_POL;
    end else if (PIX_EN) begin
      CounterX   <= x_next;
      CounterY   <= y_next;
      ActiveArea <= active_next;
      FrameStart <= frame_next;
      hs_raw     <= hs_next;
      vs_raw     <= vs_next;
    end
  end

  assign delay_in = '{hs: hs_raw, vs: vs_raw, active: ActiveArea};

  vga_sync_delay #(
    .DEPTH    (PIPE_DELAY),
    .WIDTH    ($bits(sync_bits_t)),
    .INACTIVE (SYNC_IDLE)
  ) u_sync_delay (
    .clk  (CLOCK),
    .rst  (RESET),
    .en   (PIX_EN),
    .din  (delay_in),
    .dout (delay_out)
  );

  assign VGA_HS      = delay_out.hs;
  assign VGA_VS      = delay_out.vs;
  assign VGA_BLANK_N = delay_out.active;
  assign VGA_SYNC_N  = 1'b0;

endmodule
